// File: rtl/pe_traffic_gen.sv
// Traffic-generator / sink processing element for HNoC tiles.
// The source injects PKT_LIMIT {dest,data} packets; the sink counts and checksums ejected packets.
module pe_traffic_gen #(
    parameter int unsigned ADDRESS     = 0,
    parameter int unsigned NUM_PE      = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TOTAL_WIDTH = 35,
    parameter int unsigned PKT_LIMIT   = 100,
    parameter int unsigned GAP         = 0,
    parameter int unsigned MODE        = 0,
    parameter int unsigned FIXED_DEST  = 0,
    parameter int unsigned ALLOW_SELF  = 1,
    parameter logic [15:0] SEED        = 16'h1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    input  logic                   i_data_valid,
    output logic                   o_data_ready,
    input  logic                   i_rx_hold,
    output logic [TOTAL_WIDTH-1:0] o_data,
    output logic                   o_data_valid,
    input  logic                   i_data_ready,
    input  logic                   i_enable,
    output logic [CNT_WIDTH-1:0]   o_tx_count,
    output logic [CNT_WIDTH-1:0]   o_rx_count,
    output logic [CNT_WIDTH-1:0]   o_rx_err,
    output logic [DATA_WIDTH-1:0]  o_rx_checksum,
    output logic                   o_tx_done
);

    localparam int unsigned SEQ_W = (PKT_LIMIT < 2) ? 1 : $clog2(PKT_LIMIT);
    localparam int unsigned GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [15:0] SEED_X   = SEED ^ 16'(ADDRESS);
    localparam logic [15:0] EFF_SEED = (SEED_X == 16'h0) ? 16'hACE1 : SEED_X;
    localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(PKT_LIMIT * ADDRESS);
    localparam logic [SEQ_W-1:0] LAST = SEQ_W'(PKT_LIMIT - 1);
    localparam logic [ADDR_WIDTH-1:0] SELF_ADDR = ADDR_WIDTH'(ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] SELF_ALT  = ADDR_WIDTH'((ADDRESS + 1) % NUM_PE);
    localparam logic [ADDR_WIDTH-1:0] INV_ADDR  = ~SELF_ADDR;
    localparam logic [ADDR_WIDTH-1:0] COMP_DEST =
        (32'(INV_ADDR) >= NUM_PE) ? INV_ADDR - ADDR_WIDTH'(NUM_PE) : INV_ADDR;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                r_state;
    logic [SEQ_W-1:0]      r_seq;
    logic [GAP_W-1:0]      r_gap;
    logic [15:0]           r_lfsr;
    logic                  r_rx_en;

    logic [15:0]           w_lfsr_nxt;
    logic [ADDR_WIDTH-1:0] w_dest_now;
    logic [ADDR_WIDTH-1:0] w_dest_nxt;
    logic [DATA_WIDTH-1:0] w_data_now;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_rx_fire;

    // Fold the raw LFSR slice into [0, NUM_PE) and optionally steer away from self.
    function automatic logic [ADDR_WIDTH-1:0] uni_dest(input logic [ADDR_WIDTH-1:0] r);
        logic [ADDR_WIDTH-1:0] d;
        d = (32'(r) >= NUM_PE) ? r - ADDR_WIDTH'(NUM_PE) : r;
        if (ALLOW_SELF == 0 && d == SELF_ADDR)
            d = SELF_ALT;
        return d;
    endfunction

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign w_dest_now = (MODE == 2) ? ADDR_WIDTH'(FIXED_DEST) :
                        (MODE == 1) ? COMP_DEST : uni_dest(r_lfsr[ADDR_WIDTH-1:0]);
    assign w_dest_nxt = (MODE == 2) ? ADDR_WIDTH'(FIXED_DEST) :
                        (MODE == 1) ? COMP_DEST : uni_dest(w_lfsr_nxt[ADDR_WIDTH-1:0]);

    assign w_data_now = BASE + DATA_WIDTH'(r_seq);
    assign w_data_nxt = w_data_now + DATA_WIDTH'(1);

    // The "next" packet is only used when chaining back-to-back within SEND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_seq        <= '0;
            r_gap        <= '0;
            r_lfsr       <= EFF_SEED;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_tx_count   <= '0;
            o_tx_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PKT_LIMIT == 0) begin
                        r_state   <= S_DONE;
                        o_tx_done <= 1'b1;
                    end else if (i_enable) begin
                        r_state      <= S_SEND;
                        o_data_valid <= 1'b1;
                        o_data       <= {w_dest_now, w_data_now};
                    end
                end
                S_SEND: begin
                    if (i_data_ready) begin
                        if (o_tx_count != '1)
                            o_tx_count <= o_tx_count + CNT_WIDTH'(1);
                        r_seq  <= r_seq + SEQ_W'(1);
                        r_lfsr <= w_lfsr_nxt;
                        if (r_seq == LAST) begin
                            r_state      <= S_DONE;
                            o_data_valid <= 1'b0;
                            o_tx_done    <= 1'b1;
                        end else if (GAP == 0) begin
                            if (i_enable) begin
                                o_data <= {w_dest_nxt, w_data_nxt};
                            end else begin
                                r_state      <= S_IDLE;
                                o_data_valid <= 1'b0;
                            end
                        end else begin
                            r_state      <= S_GAP;
                            o_data_valid <= 1'b0;
                            r_gap        <= GAP_W'(GAP - 1);
                        end
                    end
                end
                S_GAP: begin
                    // Counter starts at GAP-1 so exactly GAP cycles pass with valid low.
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GAP_W'(1);
                    end else if (i_enable) begin
                        r_state      <= S_SEND;
                        o_data_valid <= 1'b1;
                        o_data       <= {w_dest_now, w_data_now};
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data_ready = r_rx_en & ~i_rx_hold;
    assign w_rx_fire    = i_data_valid & o_data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_en       <= 1'b0;
            o_rx_count    <= '0;
            o_rx_err      <= '0;
            o_rx_checksum <= '0;
        end else begin
            r_rx_en <= 1'b1;
            if (w_rx_fire) begin
                if (o_rx_count != '1)
                    o_rx_count <= o_rx_count + CNT_WIDTH'(1);
                if (i_data[DATA_WIDTH +: ADDR_WIDTH] != SELF_ADDR && o_rx_err != '1)
                    o_rx_err <= o_rx_err + CNT_WIDTH'(1);
                o_rx_checksum <= o_rx_checksum + i_data[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Self-checking bench for pe_traffic_gen: four parameterisations sharing clock and reset,
// source packets and sink status checked against bench-side queues.
module tb_pe_traffic_gen;

    typedef logic [34:0] pkt_t;
    typedef struct {
        logic [1:0]  cnt;
        logic [1:0]  err;
        logic [31:0] sum;
    } sk_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    pkt_t sb[$];
    logic [31:0] dq[$];
    sk_t  skq[$];

    // u1: MODE1, ADDRESS=2, 4 packets back-to-back
    logic a_en = 0, a_rdy = 0, a_val, a_done, a_drdy;
    pkt_t a_dat;
    logic [15:0] a_tx, a_rxc, a_rxe;
    logic [31:0] a_sum;
    pe_traffic_gen #(.ADDRESS(2), .NUM_PE(8), .ADDR_WIDTH(3), .DATA_WIDTH(32), .TOTAL_WIDTH(35),
                     .PKT_LIMIT(4), .GAP(0), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .i_data(35'd0), .i_data_valid(1'b0), .o_data_ready(a_drdy),
        .i_rx_hold(1'b0), .o_data(a_dat), .o_data_valid(a_val), .i_data_ready(a_rdy),
        .i_enable(a_en), .o_tx_count(a_tx), .o_rx_count(a_rxc), .o_rx_err(a_rxe),
        .o_rx_checksum(a_sum), .o_tx_done(a_done));

    // u3: MODE2 FIXED_DEST=6, GAP=3, ADDRESS=1, 6 packets
    logic b_en = 0, b_rdy = 0, b_val, b_done, b_drdy;
    pkt_t b_dat;
    logic [15:0] b_tx, b_rxc, b_rxe;
    logic [31:0] b_sum;
    pe_traffic_gen #(.ADDRESS(1), .NUM_PE(8), .ADDR_WIDTH(3), .DATA_WIDTH(32), .TOTAL_WIDTH(35),
                     .PKT_LIMIT(6), .GAP(3), .MODE(2), .FIXED_DEST(6)) u3 (
        .clk(clk), .rst(rst), .i_data(35'd0), .i_data_valid(1'b0), .o_data_ready(b_drdy),
        .i_rx_hold(1'b0), .o_data(b_dat), .o_data_valid(b_val), .i_data_ready(b_rdy),
        .i_enable(b_en), .o_tx_count(b_tx), .o_rx_count(b_rxc), .o_rx_err(b_rxe),
        .o_rx_checksum(b_sum), .o_tx_done(b_done));

    // u5: sink with 2-bit counters, ADDRESS=1, no injection
    logic c_en = 0, c_dv = 0, c_hold = 0, c_val, c_done, c_drdy;
    pkt_t c_din = '0, c_dat;
    logic [1:0] c_tx, c_rxc, c_rxe;
    logic [31:0] c_sum;
    pe_traffic_gen #(.ADDRESS(1), .NUM_PE(8), .ADDR_WIDTH(3), .DATA_WIDTH(32), .TOTAL_WIDTH(35),
                     .PKT_LIMIT(0), .CNT_WIDTH(2)) u5 (
        .clk(clk), .rst(rst), .i_data(c_din), .i_data_valid(c_dv), .o_data_ready(c_drdy),
        .i_rx_hold(c_hold), .o_data(c_dat), .o_data_valid(c_val), .i_data_ready(1'b1),
        .i_enable(c_en), .o_tx_count(c_tx), .o_rx_count(c_rxc), .o_rx_err(c_rxe),
        .o_rx_checksum(c_sum), .o_tx_done(c_done));

    // u6: MODE0, NUM_PE=6, ALLOW_SELF=0, ADDRESS=3, 1000 packets
    logic d_en = 0, d_rdy = 0, d_val, d_done, d_drdy;
    pkt_t d_dat;
    logic [15:0] d_tx, d_rxc, d_rxe;
    logic [31:0] d_sum;
    pe_traffic_gen #(.ADDRESS(3), .NUM_PE(6), .ADDR_WIDTH(3), .DATA_WIDTH(32), .TOTAL_WIDTH(35),
                     .PKT_LIMIT(1000), .GAP(0), .MODE(0), .ALLOW_SELF(0)) u6 (
        .clk(clk), .rst(rst), .i_data(35'd0), .i_data_valid(1'b0), .o_data_ready(d_drdy),
        .i_rx_hold(1'b0), .o_data(d_dat), .o_data_valid(d_val), .i_data_ready(d_rdy),
        .i_enable(d_en), .o_tx_count(d_tx), .o_rx_count(d_rxc), .o_rx_err(d_rxe),
        .o_rx_checksum(d_sum), .o_tx_done(d_done));

    task automatic reset_all();
        a_en = 0; a_rdy = 0; b_en = 0; b_rdy = 0;
        c_en = 0; c_dv = 0; c_hold = 0; c_din = '0;
        d_en = 0; d_rdy = 0;
        sb.delete(); dq.delete(); skq.delete();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_all();
        a_en = 1; a_rdy = 0;
        repeat (3) @(negedge clk);
        total++;
        if (a_val !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", a_val); end
        #2 rst = 0;
        #1;
        total++;
        if (a_val !== 1'b0 || a_dat !== 35'd0) begin
            bad++; $display("FAIL reset_source got valid=%b data=%h want valid=0 data=0", a_val, a_dat);
        end
        total++;
        if (a_tx !== 16'd0 || a_done !== 1'b0) begin
            bad++; $display("FAIL reset_tx got tx=%0d done=%b want 0 0", a_tx, a_done);
        end
        total++;
        if (c_drdy !== 1'b0 || c_rxc !== 2'd0 || c_rxe !== 2'd0 || c_sum !== 32'd0) begin
            bad++; $display("FAIL reset_sink got rdy=%b rx=%0d err=%0d sum=%0d want 0 0 0 0",
                            c_drdy, c_rxc, c_rxe, c_sum);
        end
    endtask

    task automatic test_mode1_burst();
        int n, first;
        pkt_t exp;
        reset_all();
        for (int i = 0; i < 4; i++) sb.push_back({3'd5, 32'(8 + i)});
        a_rdy = 1; a_en = 1; n = 0; first = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (a_val && a_rdy) begin
                if (first < 0) first = cyc;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL burst_extra got=%h want=none", a_dat);
                end else begin
                    exp = sb.pop_front();
                    if (a_dat !== exp) begin bad++; $display("FAIL burst_pkt got=%h want=%h", a_dat, exp); end
                end
                total++;
                if (cyc !== first + n) begin
                    bad++; $display("FAIL burst_spacing got cycle=%0d want=%0d", cyc, first + n);
                end
                n++;
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL burst_missing got left=%0d want=0", sb.size()); end
        total++;
        if (a_done !== 1'b1) begin bad++; $display("FAIL burst_done got=%b want=1", a_done); end
        total++;
        if (a_tx !== 16'd4) begin bad++; $display("FAIL burst_txcount got=%0d want=4", a_tx); end
        total++;
        if (a_val !== 1'b0) begin bad++; $display("FAIL burst_valid_after got=%b want=0", a_val); end
    endtask

    task automatic test_stall();
        logic held;
        pkt_t hdat, exp;
        reset_all();
        for (int i = 0; i < 4; i++) sb.push_back({3'd5, 32'(8 + i)});
        a_en = 1; a_rdy = 1; held = 0; hdat = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (held) begin
                total++;
                if (a_val !== 1'b1 || a_dat !== hdat) begin
                    bad++; $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h", a_val, a_dat, hdat);
                end
            end
            a_rdy = !(cyc >= 2 && cyc < 7);
            held = 0;
            if (a_val && a_rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL stall_extra got=%h want=none", a_dat);
                end else begin
                    exp = sb.pop_front();
                    if (a_dat !== exp) begin bad++; $display("FAIL stall_pkt got=%h want=%h", a_dat, exp); end
                end
            end else if (a_val) begin
                held = 1; hdat = a_dat;
            end
        end
        total++;
        if (sb.size() != 0 || a_tx !== 16'd4) begin
            bad++; $display("FAIL stall_total got left=%0d tx=%0d want left=0 tx=4", sb.size(), a_tx);
        end
    endtask

    task automatic test_gap();
        int last;
        pkt_t exp;
        reset_all();
        for (int i = 0; i < 6; i++) sb.push_back({3'd6, 32'(6 + i)});
        b_rdy = 1; b_en = 1; last = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (b_val) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL gap_extra got=%h want=none", b_dat);
                end else begin
                    exp = sb.pop_front();
                    if (b_dat !== exp) begin bad++; $display("FAIL gap_pkt got=%h want=%h", b_dat, exp); end
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 4) begin
                        bad++; $display("FAIL gap_spacing got=%0d want=4", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        total++;
        if (sb.size() != 0 || b_done !== 1'b1 || b_tx !== 16'd6) begin
            bad++; $display("FAIL gap_end got left=%0d done=%b tx=%0d want 0 1 6", sb.size(), b_done, b_tx);
        end
    endtask

    task automatic test_gap_pause();
        int n, down, up;
        logic resumed;
        pkt_t exp;
        reset_all();
        for (int i = 0; i < 6; i++) sb.push_back({3'd6, 32'(6 + i)});
        b_rdy = 1; b_en = 1; n = 0; down = -1; up = -1; resumed = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (down >= 0 && up < 0 && cyc > down) begin
                total++;
                if (b_val !== 1'b0) begin bad++; $display("FAIL pause_valid got=%b want=0", b_val); end
            end
            if (b_val) begin
                if (up >= 0 && !resumed) begin
                    total++;
                    if (cyc != up + 1) begin
                        bad++; $display("FAIL pause_resume got cycle=%0d want=%0d", cyc, up + 1);
                    end
                    resumed = 1;
                end
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL pause_extra got=%h want=none", b_dat);
                end else begin
                    exp = sb.pop_front();
                    if (b_dat !== exp) begin bad++; $display("FAIL pause_pkt got=%h want=%h", b_dat, exp); end
                end
                n++;
                if (n == 2) begin b_en = 0; down = cyc; end
            end
            if (down >= 0 && up < 0 && cyc == down + 10) begin b_en = 1; up = cyc; end
        end
        total++;
        if (sb.size() != 0 || !resumed || b_done !== 1'b1) begin
            bad++; $display("FAIL pause_end got left=%0d resumed=%b done=%b want 0 1 1", sb.size(), resumed, b_done);
        end
    endtask

    task automatic test_sink();
        int   dst[7] = '{1, 1, 3, 1, 2, 0, 5};
        int   dat[7] = '{10, 20, 5, 7, 1, 2, 4};
        bit   hld[7] = '{0, 0, 0, 1, 0, 0, 0};
        logic [1:0]  m_cnt, m_err;
        logic [31:0] m_sum;
        sk_t  sk;
        reset_all();
        c_en = 1;
        total++;
        if (c_done !== 1'b1 || c_val !== 1'b0) begin
            bad++; $display("FAIL zero_limit got done=%b valid=%b want 1 0", c_done, c_val);
        end
        m_cnt = 0; m_err = 0; m_sum = 0;
        for (int i = 0; i < 7; i++) begin
            c_din  = {3'(dst[i]), 32'(dat[i])};
            c_dv   = 1;
            c_hold = hld[i];
            if (!hld[i]) begin
                if (m_cnt != 2'd3) m_cnt++;
                if (dst[i] != 1 && m_err != 2'd3) m_err++;
                m_sum = m_sum + 32'(dat[i]);
            end
            skq.push_back('{m_cnt, m_err, m_sum});
            #1;
            total++;
            if (c_drdy !== !hld[i]) begin
                bad++; $display("FAIL sink_ready step=%0d got=%b want=%b", i, c_drdy, !hld[i]);
            end
            @(negedge clk);
            sk = skq.pop_front();
            total++;
            if (c_rxc !== sk.cnt || c_rxe !== sk.err || c_sum !== sk.sum) begin
                bad++; $display("FAIL sink_status step=%0d got rx=%0d err=%0d sum=%0d want rx=%0d err=%0d sum=%0d",
                                i, c_rxc, c_rxe, c_sum, sk.cnt, sk.err, sk.sum);
            end
        end
        c_dv = 0;
        c_hold = 0;
    endtask

    task automatic test_uniform();
        int n, found;
        logic [31:0] exp;
        reset_all();
        for (int i = 0; i < 1000; i++) dq.push_back(32'(3000 + i));
        d_en = 1; n = 0;
        for (int cyc = 0; cyc < 5000 && n < 1000; cyc++) begin
            @(negedge clk);
            d_rdy = ($urandom_range(0, 3) != 0);
            if (d_val && d_rdy) begin
                exp = dq.pop_front();
                total++;
                if (d_dat[31:0] !== exp) begin
                    bad++; $display("FAIL uniform_data got=%0d want=%0d", d_dat[31:0], exp);
                end
                total++;
                if (d_dat[34:32] == 3'd3 || d_dat[34:32] >= 3'd6) begin
                    bad++; $display("FAIL uniform_dest got=%0d want !=3 and <6", d_dat[34:32]);
                end
                n++;
            end
        end
        @(negedge clk);
        total++;
        if (n != 1000 || d_done !== 1'b1 || d_tx !== 16'd1000 || d_val !== 1'b0) begin
            bad++; $display("FAIL uniform_end got n=%0d done=%b tx=%0d valid=%b want 1000 1 1000 0",
                            n, d_done, d_tx, d_val);
        end

        reset_all();
        d_en = 1; d_rdy = 1;
        repeat (6) @(negedge clk);
        total++;
        if (d_val !== 1'b1 || d_tx !== 16'd5) begin
            bad++; $display("FAIL midreset_pre got valid=%b tx=%0d want 1 5", d_val, d_tx);
        end
        #2 rst = 0;
        #1;
        total++;
        if (d_val !== 1'b0 || d_tx !== 16'd0) begin
            bad++; $display("FAIL midreset_async got valid=%b tx=%0d want 0 0", d_val, d_tx);
        end
        @(negedge clk);
        rst = 1;
        found = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (d_val) begin
                total++;
                if (d_dat[31:0] !== 32'd3000) begin
                    bad++; $display("FAIL midreset_restart got=%0d want=3000", d_dat[31:0]);
                end
                found = 1;
                break;
            end
        end
        total++;
        if (found == 0) begin bad++; $display("FAIL midreset_timeout got=none want=packet"); end
    endtask

    initial begin
        test_reset();
        test_mode1_burst();
        test_stall();
        test_gap();
        test_gap_pause();
        test_sink();
        test_uniform();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
